// File: rtl/phy_rx_multilane_if.sv
// Receive-side bundle of the multilane PHY: serial lane inputs in, unstriped
// words and per-lane status out.
interface phy_rx_multilane_if #(
    parameter int LANES  = 2,
    parameter int WORD_W = 32
);
    logic [LANES-1:0]  data_serial;
    logic [LANES-1:0]  active;
    logic              link_up;
    logic [WORD_W-1:0] data_output;
    logic              valid_out;
    logic [LANES-1:0]  err_abort;
    logic [LANES-1:0]  err_ovf;

    modport master (
        input  data_serial,
        output active, link_up, data_output, valid_out, err_abort, err_ovf
    );

    modport slave (
        output data_serial,
        input  active, link_up, data_output, valid_out, err_abort, err_ovf
    );
endinterface

// File: rtl/phy_rx_multilane.sv
// N-lane serial receive path on one bit clock: per-lane COM alignment and word
// packing, per-lane deskew FIFOs, and a strict round-robin unstriper.
module phy_rx_multilane #(
    parameter int         LANES      = 2,
    parameter int         WORD_W     = 32,
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDL        = 8'h7C,
    parameter int         ALIGN_CNT  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic               clk_32f,
    input  logic               reset,
    phy_rx_multilane_if.master rx
);
    localparam int NB   = WORD_W / 8;
    localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CCW  = $clog2(ALIGN_CNT + 1);
    localparam int RRW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {HUNT, LOCK, ACTIVE} lane_st_t;

    logic [LANES-1:0]  w_active;
    logic [LANES-1:0]  w_abort;
    logic [LANES-1:0]  w_ovf;
    logic [LANES-1:0]  w_empty;
    logic [LANES-1:0]  w_pop;
    logic [WORD_W-1:0] w_head [LANES];
    logic              w_link_up;

    logic [RRW-1:0]    r_rr;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_st_t          r_state;
            logic [7:0]        r_sh;
            logic [2:0]        r_bc;
            logic [CCW-1:0]    r_com_cnt;
            logic [CNTW-1:0]   r_cnt;
            logic [WORD_W-1:0] r_asm;
            logic              r_active;
            logic              r_abort;
            logic              r_ovf;
            logic [PW-1:0]     r_wptr;
            logic [PW-1:0]     r_rptr;
            logic [WORD_W-1:0] r_mem [FIFO_DEPTH];

            logic              w_bnd;
            logic              w_data_byte;
            logic              w_last;
            logic              w_push;
            logic              w_full;
            logic              w_wr;
            logic [WORD_W+7:0] w_cat;
            logic [WORD_W-1:0] w_word;

            // r_sh holds a complete byte on the edge where bc wraps 7->0
            assign w_bnd       = (r_bc == 3'd7);
            assign w_data_byte = (r_state == ACTIVE) && w_bnd && (r_sh != COM) && (r_sh != IDL);
            assign w_last      = (r_cnt == CNTW'(NB - 1));
            assign w_push      = w_data_byte && w_last;
            assign w_cat       = {r_asm, r_sh};
            assign w_word      = w_cat[WORD_W-1:0];
            assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts
            assign w_wr        = w_push && (!w_full || w_pop[gi]);

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    r_state   <= HUNT;
                    r_sh      <= '0;
                    r_bc      <= '0;
                    r_com_cnt <= '0;
                    r_cnt     <= '0;
                    r_active  <= 1'b0;
                    r_abort   <= 1'b0;
                end else begin
                    r_sh <= {r_sh[6:0], rx.data_serial[gi]};
                    r_bc <= r_bc + 3'd1;
                    unique case (r_state)
                        HUNT: begin
                            if (r_sh == COM) begin
                                r_bc      <= '0;
                                r_com_cnt <= CCW'(1);
                                if (ALIGN_CNT <= 1) begin
                                    r_state  <= ACTIVE;
                                    r_active <= 1'b1;
                                end else begin
                                    r_state <= LOCK;
                                end
                            end
                        end
                        LOCK: begin
                            if (w_bnd) begin
                                if (r_sh == COM) begin
                                    r_com_cnt <= r_com_cnt + 1'b1;
                                    if (r_com_cnt == CCW'(ALIGN_CNT - 1)) begin
                                        r_state  <= ACTIVE;
                                        r_active <= 1'b1;
                                    end
                                end else begin
                                    r_state   <= HUNT;
                                    r_com_cnt <= '0;
                                end
                            end
                        end
                        ACTIVE: begin
                            if (w_bnd) begin
                                if (r_sh == COM) begin
                                    if (r_cnt != '0) r_abort <= 1'b1;
                                    r_cnt <= '0;
                                end else if (r_sh != IDL) begin
                                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                                end
                            end
                        end
                        default: r_state <= HUNT;
                    endcase
                end
            end

            // Bytes shift in at the LSB end, so the first byte of a word ends in the MSBs
            always_ff @(posedge clk_32f) begin
                if (w_data_byte) r_asm <= w_word;
            end

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + 1'b1;
                    end else if (w_push) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_pop[gi]) r_rptr <= r_rptr + 1'b1;
                end
            end

            always_ff @(posedge clk_32f) begin
                if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_word;
            end

            assign w_empty[gi]  = (r_wptr == r_rptr);
            assign w_head[gi]   = r_mem[r_rptr[AW-1:0]];
            assign w_active[gi] = r_active;
            assign w_abort[gi]  = r_abort;
            assign w_ovf[gi]    = r_ovf;
        end
    endgenerate

    assign w_link_up = &w_active;

    // Strict turn order: the lane under rr must supply a word before any other lane pops
    always_comb begin
        w_pop = '0;
        if (w_link_up && !w_empty[r_rr]) w_pop[r_rr] = 1'b1;
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_rr    <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (|w_pop) begin
                r_valid <= 1'b1;
                r_data  <= w_head[r_rr];
                r_rr    <= (r_rr == RRW'(LANES - 1)) ? '0 : r_rr + 1'b1;
            end
        end
    end

    assign rx.active      = w_active;
    assign rx.link_up     = w_link_up;
    assign rx.data_output = r_data;
    assign rx.valid_out   = r_valid;
    assign rx.err_abort   = w_abort;
    assign rx.err_ovf     = w_ovf;
endmodule

// File: tb/tb_phy_rx_multilane.sv
// Bench for phy_rx_multilane: byte-level lane streams are serialised onto the
// lanes and every cycle is compared against a queue-based reference model.
module tb_phy_rx_multilane;
    localparam int         LANES      = 2;
    localparam int         WORD_W     = 32;
    localparam int         ALIGN_CNT  = 4;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] IDL        = 8'h7C;
    localparam int         NB         = WORD_W / 8;
    localparam int         INF        = 1 << 30;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_32f = ~clk_32f;

    phy_rx_multilane_if #(.LANES(LANES), .WORD_W(WORD_W)) bus ();

    phy_rx_multilane #(
        .LANES(LANES), .WORD_W(WORD_W), .COM(COM), .IDL(IDL),
        .ALIGN_CNT(ALIGN_CNT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .rx     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus: byte stream per lane, preceded by lag zero bits, followed by IDL fill
    logic [7:0]        q       [LANES][$];
    int                lag     [LANES];

    // Reference model state
    int                act_edge[LANES];
    int                abt_edge[LANES];
    int                pe_edge [LANES][$];
    logic [WORD_W-1:0] pe_word [LANES][$];
    logic [WORD_W-1:0] mf      [LANES][$];
    int                m_rr;
    logic [LANES-1:0]  m_ovf;
    logic              m_valid;
    logic [WORD_W-1:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < LANES; i++) begin
            q[i].delete();
            lag[i] = 0;
        end
    endtask

    task automatic add_n(input int ln, input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) q[ln].push_back(b);
    endtask

    task automatic add_w(input int ln, input logic [WORD_W-1:0] w);
        for (int k = NB - 1; k >= 0; k--) q[ln].push_back(w[8*k +: 8]);
    endtask

    function automatic logic [7:0] rnd_data();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == COM || b == IDL);
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < NB; k++) w = {w[WORD_W-9:0], rnd_data()};
        return w;
    endfunction

    function automatic logic get_bit(input int ln, input int k);
        int         idx;
        logic [7:0] b;
        idx = k - lag[ln];
        if (idx < 0) return 1'b0;
        if (idx / 8 < q[ln].size()) b = q[ln][idx / 8];
        else                        b = IDL;
        return b[3'(7 - idx % 8)];
    endfunction

    // Byte-level view of each lane: when it locks, when it aborts, which words it emits and when
    task automatic build_model();
        int                run;
        int                nb;
        int                e;
        logic              on;
        logic [7:0]        b;
        logic [WORD_W-1:0] acc;
        for (int i = 0; i < LANES; i++) begin
            act_edge[i] = INF;
            abt_edge[i] = INF;
            pe_edge[i].delete();
            pe_word[i].delete();
            mf[i].delete();
            run = 0; nb = 0; on = 1'b0; acc = '0;
            for (int j = 0; j < q[i].size(); j++) begin
                b = q[i][j];
                e = lag[i] + 8 * j + 8;
                if (!on) begin
                    run = (b == COM) ? run + 1 : 0;
                    if (run >= ALIGN_CNT) begin
                        on = 1'b1;
                        act_edge[i] = e;
                    end
                end else if (b == COM) begin
                    if (nb != 0 && abt_edge[i] == INF) abt_edge[i] = e;
                    nb = 0;
                end else if (b != IDL) begin
                    acc = {acc[WORD_W-9:0], b};
                    nb++;
                    if (nb == NB) begin
                        pe_edge[i].push_back(e);
                        pe_word[i].push_back(acc);
                        nb = 0;
                    end
                end
            end
        end
        m_rr = 0; m_ovf = '0; m_valid = 1'b0; m_data = '0;
    endtask

    // Advance the FIFO/unstriper model across clock edge k
    task automatic model_edge(input int k);
        int                pre [LANES];
        int                popl;
        logic              lu;
        logic [WORD_W-1:0] w;
        lu = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (act_edge[i] >= k) lu = 1'b0;
            pre[i] = mf[i].size();
        end
        popl    = -1;
        m_valid = 1'b0;
        if (lu && mf[m_rr].size() > 0) begin
            m_data  = mf[m_rr].pop_front();
            m_valid = 1'b1;
            popl    = m_rr;
            m_rr    = (m_rr + 1) % LANES;
        end
        for (int i = 0; i < LANES; i++) begin
            if (pe_edge[i].size() > 0 && pe_edge[i][0] == k) begin
                void'(pe_edge[i].pop_front());
                w = pe_word[i].pop_front();
                if (pre[i] >= FIFO_DEPTH && popl != i) m_ovf[i] = 1'b1;
                else                                   mf[i].push_back(w);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".active"},    64'(bus.active),      64'd0);
        check_val({tag, ".link_up"},   64'(bus.link_up),     64'd0);
        check_val({tag, ".valid_out"}, 64'(bus.valid_out),   64'd0);
        check_val({tag, ".data"},      64'(bus.data_output), 64'd0);
        check_val({tag, ".err_abort"}, 64'(bus.err_abort),   64'd0);
        check_val({tag, ".err_ovf"},   64'(bus.err_ovf),     64'd0);
    endtask

    task automatic run_scn(input string name, input int reset_at);
        int               ncyc;
        logic [LANES-1:0] ea;
        logic [LANES-1:0] eb;
        logic             stop;
        reset = 1'b0;
        bus.data_serial = '0;
        @(negedge clk_32f);
        build_model();
        ncyc = 0;
        for (int i = 0; i < LANES; i++)
            if (lag[i] + 8 * q[i].size() > ncyc) ncyc = lag[i] + 8 * q[i].size();
        ncyc += 48;
        reset = 1'b1;
        stop  = 1'b0;
        for (int k = 0; k < ncyc && !stop; k++) begin
            for (int i = 0; i < LANES; i++) bus.data_serial[i] = get_bit(i, k);
            @(posedge clk_32f);
            #1;
            model_edge(k);
            for (int i = 0; i < LANES; i++) begin
                ea[i] = (act_edge[i] <= k);
                eb[i] = (abt_edge[i] <= k);
            end
            check_val({name, ".active"},    64'(bus.active),      64'(ea));
            check_val({name, ".link_up"},   64'(bus.link_up),     64'(&ea));
            check_val({name, ".valid_out"}, 64'(bus.valid_out),   64'(m_valid));
            check_val({name, ".data"},      64'(bus.data_output), 64'(m_data));
            check_val({name, ".err_abort"}, 64'(bus.err_abort),   64'(eb));
            check_val({name, ".err_ovf"},   64'(bus.err_ovf),     64'(m_ovf));
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                check_zero({name, ".midreset"});
                stop = 1'b1;
            end else begin
                @(negedge clk_32f);
            end
        end
    endtask

    initial begin
        bus.data_serial = '0;
        #2 reset = 1'b0;
        #1 check_zero("por");

        clear_lanes();
        add_n(0, COM, 4); add_w(0, 32'h11223344);
        add_n(1, COM, 4); add_w(1, 32'h55667788);
        run_scn("basic", -1);

        clear_lanes();
        lag[1] = 24;
        add_n(0, COM, 4); add_w(0, rnd_word()); add_w(0, rnd_word());
        add_n(1, COM, 4); add_w(1, rnd_word()); add_w(1, rnd_word());
        run_scn("skew24", -1);

        clear_lanes();
        add_n(0, COM, 3); add_n(0, 8'h00, 1); add_n(0, COM, 4); add_w(0, rnd_word());
        add_n(1, COM, 4); add_w(1, rnd_word());
        run_scn("relock", -1);

        clear_lanes();
        add_n(0, COM, 4);
        add_n(0, 8'h11, 1); add_n(0, IDL, 1); add_n(0, 8'h22, 1); add_n(0, 8'h33, 1); add_n(0, 8'h44, 1);
        add_n(1, COM, 4); add_w(1, rnd_word());
        run_scn("idlmid", -1);

        clear_lanes();
        add_n(0, COM, 4);
        add_n(0, 8'h11, 1); add_n(0, 8'h22, 1); add_n(0, COM, 1); add_w(0, 32'h33445566);
        add_n(1, COM, 4); add_w(1, rnd_word());
        run_scn("abort", -1);

        clear_lanes();
        add_n(0, COM, 4);
        for (int w = 0; w < 5; w++) add_w(0, rnd_word());
        add_n(1, IDL, 28); add_n(1, COM, 4);
        for (int w = 0; w < 5; w++) add_w(1, rnd_word());
        run_scn("ovf", -1);

        clear_lanes();
        add_n(0, COM, 4); add_w(0, rnd_word()); add_w(0, rnd_word());
        add_n(1, COM, 4); add_w(1, rnd_word()); add_w(1, rnd_word());
        run_scn("rstmid", 50);

        clear_lanes();
        add_w(0, 32'h11223344); add_w(1, 32'h55667788);
        run_scn("nocom", -1);

        for (int r = 0; r < 6; r++) begin
            clear_lanes();
            for (int i = 0; i < LANES; i++) begin
                lag[i] = $urandom_range(0, 30);
                add_n(i, COM, 4);
                for (int w = 0; w < 3; w++) begin
                    for (int b = 0; b < NB; b++) begin
                        if ($urandom_range(0, 5) == 0) add_n(i, IDL, 1);
                        if (b == 2 && $urandom_range(0, 7) == 0) add_n(i, COM, 1);
                        add_n(i, rnd_data(), 1);
                    end
                end
            end
            run_scn($sformatf("rand%0d", r), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
